// File: rtl/trace_addr_gen_pkg.sv
// Shared definitions for the trace address generator.
// Holds the address width, access-mode and FSM-state encodings,
// and the LFSR seed, taps and step function.
package trace_addr_gen_pkg;

    localparam int ADDR_W = 31;

    typedef enum logic [1:0] {
        MODE_SEQ    = 2'b00,
        MODE_STRIDE = 2'b01,
        MODE_LOOP   = 2'b10,
        MODE_RANDOM = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [ADDR_W-1:0] LFSR_SEED  = 31'h0000_0001;
    localparam int                LFSR_TAP_A = 31;
    localparam int                LFSR_TAP_B = 28;

    // One Fibonacci step: shift left and feed the XOR of taps 31 and 28 into bit 0.
    function automatic logic [ADDR_W-1:0] lfsr_advance(input logic [ADDR_W-1:0] cur);
        return {cur[ADDR_W-2:0], cur[LFSR_TAP_A-1] ^ cur[LFSR_TAP_B-1]};
    endfunction

endpackage

// File: rtl/trace_lfsr.sv
// 31-bit Fibonacci LFSR (taps 31,28) that steps once per enable pulse.
// Used only when trace_addr_gen is built with TRACE_RANDOM_EN.
module trace_lfsr
    import trace_addr_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [ADDR_W-1:0] state
);

    logic [ADDR_W-1:0] state_r;

    // Hold the LFSR state; reseed on reset, advance on each step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LFSR_SEED;
        end else if (step) begin
            state_r <= lfsr_advance(state_r);
        end
    end

    assign state = state_r;

endmodule

// File: rtl/trace_addr_gen.sv
// Trace address generator: issues a run of addresses to a cache model with
// valid/ready handshaking in sequential, strided, loop or random mode.
// Optional feature macro TRACE_RANDOM_EN: when defined, mode 11 walks an LFSR;
// otherwise mode 11 behaves as sequential and no LFSR is built.
module trace_addr_gen
    import trace_addr_gen_pkg::*;
#(
    parameter int LINE_SIZE   = 16,
    parameter int SECTOR_SIZE = 512
) (
    input  logic              clk_41,
    input  logic              rst_41,
    input  logic              start_41,
    input  logic              abort_41,
    input  logic [1:0]        mode_41,
    input  logic [ADDR_W-1:0] base_41,
    input  logic [ADDR_W-1:0] stride_41,
    input  logic [ADDR_W-1:0] count_41,
    input  logic              ready_41,
    output logic [ADDR_W-1:0] adder_41,
    output logic              addr_valid_41,
    output logic              busy_41,
    output logic              done_41,
    output logic [ADDR_W-1:0] issued_41
);

    localparam logic [ADDR_W-1:0] ZERO        = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE         = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LINE_STEP   = ADDR_W'(LINE_SIZE);
    localparam logic [ADDR_W-1:0] SECTOR_MASK = ADDR_W'(SECTOR_SIZE - 1);

    state_e            state_r, state_nxt_s;
    mode_e             mode_r;
    logic [ADDR_W-1:0] base_r, stride_r, count_r;
    logic [ADDR_W-1:0] addr_r, issued_r, loop_off_r;
    logic              valid_r, busy_r, done_r;

    logic              xfer_s, last_s;
    logic [ADDR_W-1:0] addr_step_s, loop_off_nxt_s;

    assign xfer_s = (state_r == ST_ISSUE) && ready_41;
    assign last_s = xfer_s && ((issued_r + ONE) == count_r);

`ifdef TRACE_RANDOM_EN
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_SIZE - 1);

    logic [ADDR_W-1:0] lfsr_s;

    trace_lfsr u_lfsr (
        .clk   (clk_41),
        .rst   (rst_41),
        .step  (xfer_s && (mode_r == MODE_RANDOM)),
        .state (lfsr_s)
    );
`endif

    // Next-state decode for the IDLE / ISSUE / DONE controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_41) begin
                    if (count_41 != ZERO) begin
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (last_s || abort_41) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Address that follows the current one once it has been transferred.
    always_comb begin
        loop_off_nxt_s = (loop_off_r + LINE_STEP) & SECTOR_MASK;
        addr_step_s    = addr_r + LINE_STEP;
        case (mode_r)
            MODE_SEQ:    addr_step_s = addr_r + LINE_STEP;
            MODE_STRIDE: addr_step_s = addr_r + stride_r;
            MODE_LOOP:   addr_step_s = base_r + loop_off_nxt_s;
`ifdef TRACE_RANDOM_EN
            MODE_RANDOM: addr_step_s = base_r + (lfsr_advance(lfsr_s) & LINE_MASK);
`else
            MODE_RANDOM: addr_step_s = addr_r + LINE_STEP;
`endif
            default:     addr_step_s = addr_r + LINE_STEP;
        endcase
    end

    // Run state, latched parameters, address/progress counters and registered flags.
    always_ff @(posedge clk_41) begin
        if (rst_41) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_SEQ;
            base_r     <= ZERO;
            stride_r   <= ZERO;
            count_r    <= ZERO;
            addr_r     <= ZERO;
            issued_r   <= ZERO;
            loop_off_r <= ZERO;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s == ST_ISSUE);
            busy_r  <= (state_nxt_s == ST_ISSUE);
            done_r  <= (state_nxt_s == ST_DONE);
            if ((state_r == ST_IDLE) && start_41) begin
                mode_r     <= mode_e'(mode_41);
                base_r     <= base_41;
                stride_r   <= stride_41;
                count_r    <= count_41;
                addr_r     <= base_41;
                issued_r   <= ZERO;
                loop_off_r <= ZERO;
            end else if (xfer_s) begin
                addr_r     <= addr_step_s;
                issued_r   <= issued_r + ONE;
                loop_off_r <= loop_off_nxt_s;
            end
        end
    end

    assign adder_41      = addr_r;
    assign addr_valid_41 = valid_r;
    assign busy_41       = busy_r;
    assign done_41       = done_r;
    assign issued_41     = issued_r;

endmodule

// File: doc/trace_addr_gen.md
TRACE_ADDR_GEN -- requirements
Module: trace_addr_gen

Interface
REQ-001 Parameter LINE_SIZE, default 16, byte step per sequential access; power of two.
REQ-002 Parameter SECTOR_SIZE, default 512, loop-mode working-set size in bytes; power of two, >= LINE_SIZE.
REQ-003 clk_41  input  1  single clock; all state updates on posedge.
REQ-004 rst_41  input  1  reset, synchronous, active-high.
REQ-005 start_41  input  1  launch request, sampled in IDLE only.
REQ-006 abort_41  input  1  terminate an in-progress run.
REQ-007 mode_41  input  2  00 sequential, 01 strided, 10 loop, 11 random/fallback.
REQ-008 base_41  input  31  first address of the run.
REQ-009 stride_41  input  31  byte step for mode 01.
REQ-010 count_41  input  31  number of accesses to issue.
REQ-011 ready_41  input  1  downstream cache model accepts the current address.
REQ-012 adder_41  output  31  address presented to the cache model.
REQ-013 addr_valid_41  output  1  adder_41 holds a valid access.
REQ-014 busy_41  output  1  high in ISSUE.
REQ-015 done_41  output  1  one-cycle completion pulse.
REQ-016 issued_41  output  31  accesses transferred in the current or last run.

Function
REQ-017 FSM states: IDLE, ISSUE, DONE.
REQ-018 IDLE, start_41=1, count_41!=0 -> ISSUE; latch mode, base, stride and count; adder_41<=base_41; issued_41<=0.
REQ-019 IDLE, start_41=1, count_41=0 -> DONE directly; no address is issued.
REQ-020 start_41 outside IDLE is ignored.
REQ-021 addr_valid_41=1 exactly while in ISSUE; adder_41 stays stable until a transfer occurs.
REQ-022 Transfer = addr_valid_41 & ready_41 at a posedge; each transfer increments issued_41 by 1.
REQ-023 Next address after a transfer:
  - mode 00: +LINE_SIZE.
  - mode 01: +stride (latched value).
  - mode 10: base + ((n+1) mod (SECTOR_SIZE/LINE_SIZE))*LINE_SIZE, where n is the transfer index.
REQ-024 All address arithmetic is modulo 2^31; carry out is discarded (wrap to 0).
REQ-025 Transfer when issued_41+1 equals the latched count -> DONE.
REQ-026 DONE lasts one cycle: done_41=1, addr_valid_41=0, then IDLE.
REQ-027 abort_41=1 in ISSUE -> DONE next cycle; issued_41 keeps its value including any transfer in that same cycle.
REQ-028 Abort and the final transfer in the same cycle -> single DONE; issued_41 = count.
REQ-029 issued_41 holds its value in IDLE until the next accepted start.
REQ-030 Latency: first address is valid the cycle after start is sampled; one access per cycle maximum when ready_41 is held high.

Reset
REQ-031 rst_41=1 at a posedge forces IDLE; adder_41=0, addr_valid_41=0, busy_41=0, done_41=0, issued_41=0, LFSR=31'h1; it dominates start and abort.
REQ-032 Reset asserted mid-run abandons the run with no done_41 pulse.

Configuration
REQ-033 Macro TRACE_RANDOM_EN:
  - Defined: mode 11 drives a 31-bit Fibonacci LFSR (taps 31,28; seed 31'h1) that advances once per transfer; adder_41 = base + (LFSR & ~(LINE_SIZE-1)), modulo 2^31.
  - Undefined: mode 11 behaves exactly as mode 00, and no LFSR logic is present.

Structure
REQ-034 Shared package holds the mode encodings, FSM state encodings, LFSR seed and taps, and the address width (31).
REQ-035 One sub-module: trace_lfsr (step enable, reset, 31-bit state), instantiated only under TRACE_RANDOM_EN.

Verification
REQ-036 Sequential run: mode 00, base 0x100, count 4, ready_41 held 1 -> adder_41 = 0x100, 0x110, 0x120, 0x130 on consecutive cycles; done_41 pulses; issued_41 = 4.
REQ-037 Backpressure: mode 01, stride 0x40, ready_41 low for 3 cycles -> adder_41 holds 0x0 until ready_41 rises, then steps to 0x40.
REQ-038 Loop wrap: mode 10, base 0x1000, count 34 -> the 33rd address is 0x1000 again and the 34th is 0x1010.
REQ-039 Wrap-around: mode 00, base 0x7FFFFFF0, count 2 -> adder_41 = 0x7FFFFFF0, then 0x00000000.
REQ-040 Edge cases:
  - count_41=0: done_41 pulses 1 cycle after start with addr_valid_41 never asserted.
  - abort_41 after 2 transfers: issued_41 = 2, single done_41 pulse.
  - rst_41 mid-run: all outputs 0 the next cycle, with no done_41 pulse.
